motor_ramp: RTL and testbench

Command shaper that sits directly upstream of each H-bridge motor controller. Accepts a signed speed command and drives the controller's `dir`, `on` and 5-bit `duty_cycle` inputs. Slews duty toward the commanded magnitude at a fixed rate. Handles reversals as brake to zero, coast, then flip direction, so the motors and H-bridges never see abrupt steps.

---
 rtl/motor_pkg.sv | 39 +++
 rtl/motor_ramp_tick.sv | 29 ++
 rtl/motor_ramp.sv | 145 ++++++++++++++
 tb/tb_motor_ramp.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/motor_pkg.sv
// Shared types, widths and the speed-to-target conversion for the motor ramp shaper.
package motor_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RAMP,
        BRAKE,
        COAST
    } state_t;

    localparam int DUTY_W   = 5;
    localparam int DUTY_MAX = 31;
    localparam int SPEED_W  = 6;

    typedef struct packed {
        logic              dir;
        logic [DUTY_W-1:0] mag;
    } target_t;

    // Zero speed keeps the previous direction so a stop does not trigger a reversal.
    function automatic target_t speed_to_target(input logic signed [SPEED_W-1:0] speed,
                                                input logic prev_dir);
        target_t                   t;
        logic signed [SPEED_W-1:0] neg;
        t.dir = prev_dir;
        t.mag = '0;
        neg   = -speed;
        if (!speed[SPEED_W-1] && (speed != '0)) begin
            t.dir = 1'b1;
            t.mag = speed[DUTY_W-1:0];
        end else if (speed[SPEED_W-1]) begin
            t.dir = 1'b0;
            // -32 has no positive 6-bit counterpart; clamp to full scale
            t.mag = (speed[DUTY_W-1:0] == '0) ? DUTY_W'(DUTY_MAX) : neg[DUTY_W-1:0];
        end
        return t;
    endfunction

endpackage

// File: rtl/motor_ramp_tick.sv
// Prescaler: pulses tick every DIV enabled cycles; load restarts the count from zero.
module motor_ramp_tick #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= (cnt_reg == LAST) ? '0 : cnt_reg + CW'(1);
        end
    end

    assign tick = en && !load && (cnt_reg == LAST);

endmodule

// File: rtl/motor_ramp.sv
// Slew-limited speed command shaper for an H-bridge: ramp, brake, coast, then reverse.
// Optional command watchdog compiled in with MOTOR_RAMP_WATCHDOG_EN.
module motor_ramp
    import motor_pkg::*;
#(
    parameter int RAMP_DIV     = 50000,
    parameter int COAST_CYCLES = 25000,
    parameter int WDT_CYCLES   = 5000000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    input  logic signed [SPEED_W-1:0] cmd_speed,
    output logic                      dir,
    output logic                      on,
    output logic [DUTY_W-1:0]         duty_cycle,
    output logic                      settled,
    output logic                      wdt_trip
);

    state_t            state_reg, state_next;
    logic [DUTY_W-1:0] duty_reg, duty_next;
    logic              dir_reg, dir_next;
    logic              on_reg, settled_reg;
    logic              tgt_dir_reg, tgt_dir_next;
    logic [DUTY_W-1:0] tgt_mag_reg, tgt_mag_next;
    logic              tick, coast_done, coast_load;
    logic              wdt_fire, wdt_trip_reg;
    target_t           cmd_tgt;

    motor_ramp_tick #(.DIV(RAMP_DIV)) u_prescale (
        .clk (clk), .rst (rst), .load (1'b0), .en (1'b1), .tick (tick)
    );

    motor_ramp_tick #(.DIV(COAST_CYCLES)) u_coast (
        .clk (clk), .rst (rst), .load (coast_load), .en (state_reg == COAST), .tick (coast_done)
    );

`ifdef MOTOR_RAMP_WATCHDOG_EN
    localparam int              WW       = $clog2(WDT_CYCLES + 1);
    localparam logic [WW-1:0]   WDT_LAST = WW'(WDT_CYCLES - 1);
    logic [WW-1:0] wdt_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdt_cnt_reg  <= '0;
            wdt_trip_reg <= 1'b0;
        end else if (cmd_valid) begin
            wdt_cnt_reg  <= '0;
            wdt_trip_reg <= 1'b0;
        end else if (wdt_fire) begin
            wdt_trip_reg <= 1'b1;
        end else if (!wdt_trip_reg) begin
            wdt_cnt_reg  <= wdt_cnt_reg + WW'(1);
        end
    end

    assign wdt_fire = !cmd_valid && !wdt_trip_reg && (wdt_cnt_reg == WDT_LAST);
`else
    assign wdt_fire     = 1'b0;
    assign wdt_trip_reg = 1'b0;
`endif

    assign cmd_tgt = speed_to_target(cmd_speed, tgt_dir_reg);

    always_comb begin
        tgt_dir_next = cmd_valid ? cmd_tgt.dir : tgt_dir_reg;
        tgt_mag_next = cmd_valid ? cmd_tgt.mag : tgt_mag_reg;
        if (wdt_fire) tgt_mag_next = '0;

        // Step decisions below see this cycle's command, even on a tick cycle.
        state_next = state_reg;
        duty_next  = duty_reg;
        dir_next   = dir_reg;
        case (state_reg)
            IDLE: begin
                duty_next = '0;
                if (tgt_mag_next != '0) begin
                    dir_next   = tgt_dir_next;
                    state_next = RAMP;
                end
            end
            RAMP: if (tick) begin
                if ((tgt_mag_next != '0) && (tgt_dir_next != dir_reg)) begin
                    state_next = BRAKE;
                end else begin
                    if (duty_reg < tgt_mag_next)      duty_next = duty_reg + DUTY_W'(1);
                    else if (duty_reg > tgt_mag_next) duty_next = duty_reg - DUTY_W'(1);
                    if ((duty_next == '0) && (tgt_mag_next == '0)) state_next = IDLE;
                end
            end
            BRAKE: if (tick) begin
                if (tgt_dir_next == dir_reg) begin
                    state_next = RAMP;
                end else begin
                    duty_next = (duty_reg == '0) ? '0 : duty_reg - DUTY_W'(1);
                    if (duty_next == '0) state_next = COAST;
                end
            end
            COAST: begin
                duty_next = '0;
                if (coast_done) begin
                    if (tgt_mag_next != '0) begin
                        dir_next   = tgt_dir_next;
                        state_next = RAMP;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign coast_load = (state_next == COAST) && (state_reg != COAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            duty_reg    <= '0;
            dir_reg     <= 1'b0;
            on_reg      <= 1'b0;
            settled_reg <= 1'b1;
            tgt_dir_reg <= 1'b0;
            tgt_mag_reg <= '0;
        end else begin
            state_reg   <= state_next;
            duty_reg    <= duty_next;
            dir_reg     <= dir_next;
            tgt_dir_reg <= tgt_dir_next;
            tgt_mag_reg <= tgt_mag_next;
            on_reg      <= ((state_next == RAMP) || (state_next == BRAKE)) && (duty_next != '0);
            settled_reg <= ((state_next == IDLE) && (tgt_mag_next == '0)) ||
                           ((state_next == RAMP) && (duty_next == tgt_mag_next) &&
                            (dir_next == tgt_dir_next));
        end
    end

    assign dir        = dir_reg;
    assign on         = on_reg;
    assign duty_cycle = duty_reg;
    assign settled    = settled_reg;
    assign wdt_trip   = wdt_trip_reg;

endmodule

// File: tb/tb_motor_ramp.sv
// Directed bench for motor_ramp with RAMP_DIV=4, COAST_CYCLES=8, WDT_CYCLES=200.
module tb_motor_ramp;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic signed [5:0] cmd_speed;
    logic              dir, on, settled, wdt_trip;
    logic [4:0]        duty_cycle;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc;
    int n;

    motor_ramp #(.RAMP_DIV(4), .COAST_CYCLES(8), .WDT_CYCLES(200)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_speed  (cmd_speed),
        .dir        (dir),
        .on         (on),
        .duty_cycle (duty_cycle),
        .settled    (settled),
        .wdt_trip   (wdt_trip)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic signed [5:0] s);
        cmd_speed = s;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        $display("cmd %0d -> dir=%0d on=%0d duty=%0d", s, dir, on, duty_cycle);
    endtask

    task automatic wait_step(output int c);
        logic [4:0] prev;
        prev = duty_cycle;
        c = 0;
        while ((duty_cycle == prev) && (c < 40)) begin
            @(negedge clk);
            c++;
        end
        if (c >= 40) begin
            n_cmp++;
            n_bad++;
            $error("FAIL step_timeout: observed no duty change expected change within 40 cycles");
        end
        $display("step duty=%0d dir=%0d on=%0d settled=%0d after %0d cycles",
                 duty_cycle, dir, on, settled, c);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_speed = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_outputs", {dir, on, duty_cycle, settled, wdt_trip}, 9'b0_0_00000_1_0);
        repeat (20) @(negedge clk);
        check("idle_outputs", {dir, on, duty_cycle, settled, wdt_trip}, 9'b0_0_00000_1_0);

        // +10 from idle
        send(6'sd10);
        check("idle_dir_load", dir, 1);
        for (int k = 1; k <= 10; k++) begin
            wait_step(cyc);
            check("up10_duty", duty_cycle, k);
            check("up10_on", on, 1);
            if (k > 1) check("up10_interval", cyc, 4);
            if (k == 5) check("up10_unsettled", settled, 0);
        end
        check("up10_settled", settled, 1);
        repeat (12) @(negedge clk);
        check("up10_no_overshoot", duty_cycle, 10);

        // reverse to -5: brake, coast, flip
        send(-6'sd5);
        for (int k = 9; k >= 0; k--) begin
            wait_step(cyc);
            check("brake_duty", duty_cycle, k);
            check("brake_dir", dir, 1);
            if (k == 9) check("brake_first_latency", cyc, 7);
            else        check("brake_interval", cyc, 4);
        end
        check("brake_off", on, 0);
        n = 0;
        while ((dir == 1'b1) && (n < 40)) begin
            @(negedge clk);
            n++;
        end
        check("coast_length", n, 8);
        check("coast_on_low", on, 0);
        for (int k = 1; k <= 5; k++) begin
            wait_step(cyc);
            check("rev_duty", duty_cycle, k);
            check("rev_dir", dir, 0);
        end
        check("rev_settled", settled, 1);

        // same direction up to 12, start reversal, cancel during brake at 6
        send(-6'sd12);
        for (int k = 6; k <= 12; k++) begin
            wait_step(cyc);
            check("up12_duty", duty_cycle, k);
        end
        send(6'sd3);
        for (int k = 11; k >= 6; k--) begin
            wait_step(cyc);
            check("brake2_duty", duty_cycle, k);
        end
        send(-6'sd8);
        wait_step(cyc);
        check("cancel_duty", duty_cycle, 7);
        check("cancel_latency", cyc, 7);
        check("cancel_dir", dir, 0);
        check("cancel_on", on, 1);
        wait_step(cyc);
        check("cancel_duty2", duty_cycle, 8);
        check("cancel_interval", cyc, 4);
        check("cancel_settled", settled, 1);

        // -32 saturates to 31
        send(-6'sd32);
        for (int k = 9; k <= 31; k++) begin
            wait_step(cyc);
            check("sat_duty", duty_cycle, k);
        end
        repeat (12) @(negedge clk);
        check("sat_hold", duty_cycle, 31);
        check("sat_settled", settled, 1);
        check("sat_dir", dir, 0);

        // stop: ramp down to idle
        send(6'sd0);
        for (int k = 30; k >= 0; k--) begin
            wait_step(cyc);
            check("stop_duty", duty_cycle, k);
        end
        check("stop_state", {dir, on, settled}, 3'b0_0_1);

        // asynchronous reset mid-ramp
        send(6'sd20);
        for (int k = 1; k <= 3; k++) wait_step(cyc);
        check("pre_reset_duty", duty_cycle, 3);
        #2 rst = 1'b1;
        #1 check("async_reset", {dir, on, duty_cycle, settled, wdt_trip}, 9'b0_0_00000_1_0);
        @(negedge clk);
        rst = 1'b0;
        $display("reset mid-ramp released");

`ifdef MOTOR_RAMP_WATCHDOG_EN
        send(6'sd10);
        n = 1;
        while (!wdt_trip && (n < 400)) begin
            @(negedge clk);
            n++;
        end
        check("wdt_latency", n, 201);
        check("wdt_trip_set", wdt_trip, 1);
        check("wdt_duty_at_trip", duty_cycle >= 5'd9, 1);
        n = 0;
        while (((duty_cycle != 0) || on) && (n < 100)) begin
            @(negedge clk);
            n++;
        end
        check("wdt_idle", {on, duty_cycle, settled, wdt_trip}, 8'b0_00000_1_1);
        send(6'sd3);
        check("wdt_clear", wdt_trip, 0);
        wait_step(cyc);
        check("wdt_resume_duty", duty_cycle, 1);
        check("wdt_resume_dir", dir, 1);
`else
        send(6'sd3);
        wait_step(cyc);
        check("no_wdt_resume_duty", duty_cycle, 1);
        repeat (250) @(negedge clk);
        check("no_wdt_trip", wdt_trip, 0);
        check("no_wdt_duty", duty_cycle, 3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
